// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage between the program counter and decode. Issues one
//               instruction-memory request at a time, waits for a variable-
//               latency response (with timeout), and buffers the word into an
//               IF/ID register with a valid/ready handshake. Supports redirect
//               flush and a single-entry hold buffer for decode back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int              XLEN      = 32,
  parameter int              MAX_WAIT  = 255,
  parameter logic [XLEN-1:0] FAULT_NOP = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            pc_advance,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
);

  localparam int             CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  hold_instr;
  logic [XLEN-1:0]  hold_pc;
  logic             hold_fault;

  // Derived control terms shared by the FSM and the datapath.
  logic            cnt_expired;
  logic            accept;
  logic            wait_done;
  logic            out_free;
  logic            load_new;
  logic            to_hold;
  logic            load_hold;
  logic [XLEN-1:0] new_instr;
  logic            new_fault;

  // A timeout is a cycle in which the counter sits at its limit with no
  // response; it then behaves like a response carrying FAULT_NOP.
  assign cnt_expired = (cnt == CNT_MAX);
  assign accept      = (state == S_REQ) && imem_req_ready && !flush;
  assign wait_done   = (state == S_WAIT) && (imem_rsp_valid || cnt_expired);
  assign out_free    = !if_valid || if_ready;
  assign load_new    = wait_done && !flush && out_free;
  assign to_hold     = wait_done && !flush && !out_free;
  assign load_hold   = (state == S_HOLD) && if_ready && !flush;
  assign new_instr   = imem_rsp_valid ? imem_rsp_data : FAULT_NOP;
  assign new_fault   = !imem_rsp_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush takes priority in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (accept) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          // A response arriving with the flush has already retired the
          // request, so there is nothing left to drain.
          state_nxt = (imem_rsp_valid || cnt_expired) ? S_REQ : S_DRAIN;
        end else if (wait_done) begin
          state_nxt = out_free ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush || if_ready) state_nxt = S_REQ;
      end
      S_DRAIN: begin
        if (!flush && (imem_rsp_valid || cnt_expired)) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request-side outputs decoded from the current state.
  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_req_addr  = (state == S_REQ) ? pc : '0;
    pc_advance     = accept;
  end

  // Wait counter: cleared on accept, counts through WAIT/DRAIN, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == S_WAIT || state == S_DRAIN) && !cnt_expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture the PC of the accepted request and park blocked responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_fault <= 1'b0;
    end else begin
      if (accept) pc_q <= pc;
      if (flush) begin
        hold_instr <= '0;
        hold_pc    <= '0;
        hold_fault <= 1'b0;
      end else if (to_hold) begin
        hold_instr <= new_instr;
        hold_pc    <= pc_q;
        hold_fault <= new_fault;
      end
    end
  end

  // IF/ID output register: load, consume, or hold stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      if_fault <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
      if_fault <= 1'b0;
    end else if (load_new) begin
      if_valid <= 1'b1;
      if_instr <= new_instr;
      if_pc    <= pc_q;
      if_fault <= new_fault;
    end else if (load_hold) begin
      if_valid <= 1'b1;
      if_instr <= hold_instr;
      if_pc    <= hold_pc;
      if_fault <= hold_fault;
    end else if (if_ready) begin
      if_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
